tx_block_framer: RTL and testbench

- Upstream feeder of the transmit chain. Accepts variable-length message bytes from the host over AXI-Stream.
- Segments each message into fixed RS information blocks of K bytes. The final block is zero-padded with a fill byte.
- Marks each block with sop on the first byte and last on the K-th byte. The RS encoder always sees complete K-byte blocks.
- Provides a registered output stage with full ready/valid backpressure, plus simple status counters.

---
 rtl/tx_block_framer.sv | 110 +++++++++++
 tb/tb_tx_block_framer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_block_framer.sv
// Segments host messages into fixed K-byte RS information blocks, zero-padding the tail
// block with FILL_BYTE, behind a registered ready/valid output stage with status counters.
module tx_block_framer #(
  parameter int         K         = 223,
  parameter logic [7:0] FILL_BYTE = 8'h00,
  parameter int         CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_axis_valid,
  output logic             s_axis_ready,
  input  logic [7:0]       s_axis_data,
  input  logic             s_axis_last,
  output logic             m_axis_valid,
  input  logic             m_axis_ready,
  output logic [7:0]       m_axis_data,
  output logic             m_axis_sop,
  output logic             m_axis_last,
  output logic             m_axis_is_pad,
  output logic [CNT_W-1:0] blocks_sent,
  output logic [CNT_W-1:0] msgs_sent,
  output logic             busy
);

  localparam int            CW       = $clog2(K);
  localparam logic [CW-1:0] LAST_POS = CW'(K - 1);

  typedef enum logic [1:0] {IDLE, DATA, PAD} state_t;

  state_t           state_q;
  logic [CW-1:0]    byte_cnt_q;
  logic             m_valid_q;
  logic [7:0]       m_data_q;
  logic             m_sop_q;
  logic             m_last_q;
  logic             m_pad_q;
  logic             m_eom_q;
  logic [CNT_W-1:0] blocks_q;
  logic [CNT_W-1:0] msgs_q;

  logic          load_en;
  logic          s_accept;
  logic          at_last;
  logic [CW-1:0] cnt_d;

  // NOTE: s_axis_ready is a pure function of registered state and m_axis_ready, so the
  // host handshake never loops back through s_axis_valid; rst_n gates it low during reset.
  assign load_en      = !m_valid_q || m_axis_ready;
  assign s_axis_ready = rst_n && load_en && (state_q != PAD);
  assign s_accept     = s_axis_valid && s_axis_ready;
  assign at_last      = (byte_cnt_q == LAST_POS);
  assign cnt_d        = at_last ? '0 : byte_cnt_q + 1'b1;

  // NOTE: all state here uses non-blocking assignments so every register samples the
  // pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      m_sop_q    <= 1'b0;
      m_last_q   <= 1'b0;
      m_pad_q    <= 1'b0;
      m_eom_q    <= 1'b0;
      blocks_q   <= '0;
      msgs_q     <= '0;
    end else begin
      if (load_en) begin
        if (state_q == PAD) begin
          m_valid_q  <= 1'b1;
          m_data_q   <= FILL_BYTE;
          m_sop_q    <= 1'b0;
          m_last_q   <= at_last;
          m_pad_q    <= 1'b1;
          m_eom_q    <= at_last;
          byte_cnt_q <= cnt_d;
          if (at_last) state_q <= IDLE;
        end else if (s_accept) begin
          m_valid_q  <= 1'b1;
          m_data_q   <= s_axis_data;
          m_sop_q    <= (byte_cnt_q == '0);
          m_last_q   <= at_last;
          m_pad_q    <= 1'b0;
          m_eom_q    <= at_last && s_axis_last;
          byte_cnt_q <= cnt_d;
          if (at_last) state_q <= s_axis_last ? IDLE : DATA;
          else         state_q <= s_axis_last ? PAD  : DATA;
        end else begin
          m_valid_q <= 1'b0;
        end
      end
      // The end-of-message flag travels with the byte, so it is valid exactly at transfer.
      if (m_valid_q && m_axis_ready && m_last_q) begin
        blocks_q <= blocks_q + 1'b1;
        if (m_eom_q) msgs_q <= msgs_q + 1'b1;
      end
    end
  end

  assign m_axis_valid  = m_valid_q;
  assign m_axis_data   = m_data_q;
  assign m_axis_sop    = m_sop_q;
  assign m_axis_last   = m_last_q;
  assign m_axis_is_pad = m_pad_q;
  assign blocks_sent   = blocks_q;
  assign msgs_sent     = msgs_q;
  assign busy          = (state_q != IDLE) || m_valid_q;

endmodule

// File: tb/tb_tx_block_framer.sv
// Scoreboard bench: instance 0 is K=223/FILL=00, instance 1 is K=4/FILL=FF. Stimulus pushes
// the expected block stream; an independent monitor pops and compares on every transfer.
module tb_tx_block_framer;

  typedef struct packed {
    logic [7:0] data;
    logic       sop;
    logic       last;
    logic       pad;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid [2];
  logic        s_ready [2];
  logic [7:0]  s_data  [2];
  logic        s_last  [2];
  logic        m_valid [2];
  logic        m_ready [2];
  logic [7:0]  m_data  [2];
  logic        m_sop   [2];
  logic        m_last  [2];
  logic        m_pad   [2];
  logic [15:0] blocks  [2];
  logic [15:0] msgs    [2];
  logic        busy    [2];

  exp_t exp_q0 [$];
  exp_t exp_q1 [$];
  int   out_cnt [2];
  int   pad_cnt [2];
  int   errors = 0;
  int   checks = 0;
  logic rand_mode = 1'b0;

  always #5 clk = ~clk;

  tx_block_framer #(.K(223), .FILL_BYTE(8'h00), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .s_axis_valid(s_valid[0]), .s_axis_ready(s_ready[0]),
    .s_axis_data(s_data[0]), .s_axis_last(s_last[0]),
    .m_axis_valid(m_valid[0]), .m_axis_ready(m_ready[0]),
    .m_axis_data(m_data[0]), .m_axis_sop(m_sop[0]),
    .m_axis_last(m_last[0]), .m_axis_is_pad(m_pad[0]),
    .blocks_sent(blocks[0]), .msgs_sent(msgs[0]), .busy(busy[0])
  );

  tx_block_framer #(.K(4), .FILL_BYTE(8'hFF), .CNT_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .s_axis_valid(s_valid[1]), .s_axis_ready(s_ready[1]),
    .s_axis_data(s_data[1]), .s_axis_last(s_last[1]),
    .m_axis_valid(m_valid[1]), .m_axis_ready(m_ready[1]),
    .m_axis_data(m_data[1]), .m_axis_sop(m_sop[1]),
    .m_axis_last(m_last[1]), .m_axis_is_pad(m_pad[1]),
    .blocks_sent(blocks[1]), .msgs_sent(msgs[1]), .busy(busy[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int q_size(input int d);
    return (d == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  task automatic push_exp(input int d, input exp_t e);
    if (d == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
  endtask

  // Golden segmentation: payload bytes at positions i mod k, then fill up to the block end.
  task automatic push_msg(input int d, input int k, input logic [7:0] fill,
                          input int len, input logic [7:0] seed);
    exp_t e;
    int   tail;
    for (int i = 0; i < len; i++) begin
      e.data = 8'(seed + i);
      e.sop  = ((i % k) == 0);
      e.last = ((i % k) == k - 1);
      e.pad  = 1'b0;
      push_exp(d, e);
    end
    tail = len % k;
    if (tail != 0) begin
      for (int p = tail; p < k; p++) begin
        e.data = fill;
        e.sop  = 1'b0;
        e.last = (p == k - 1);
        e.pad  = 1'b1;
        push_exp(d, e);
      end
    end
  endtask

  // Must be entered #1 after a posedge; returns in the same phase.
  task automatic send_msg(input int d, input int k, input logic [7:0] fill, input int len,
                          input logic [7:0] seed, output int first_wait);
    logic acc;
    int   waits;
    push_msg(d, k, fill, len, seed);
    first_wait = 0;
    for (int i = 0; i < len; i++) begin
      s_valid[d] = 1'b1;
      s_data[d]  = 8'(seed + i);
      s_last[d]  = (i == len - 1);
      waits = 0;
      acc   = 1'b0;
      while (!acc && waits < 2000) begin
        @(negedge clk);
        acc = s_ready[d];
        @(posedge clk);
        #1;
        if (!acc) waits++;
      end
      if (i == 0) first_wait = waits;
      if (!acc) begin
        check("send_timeout", 32'(acc), 32'd1);
        break;
      end
    end
    s_valid[d] = 1'b0;
    s_last[d]  = 1'b0;
  endtask

  task automatic drain(input int d, input int budget);
    int c = 0;
    while ((q_size(d) != 0 || m_valid[d]) && c < budget) begin
      @(posedge clk);
      #1;
      c++;
    end
    check($sformatf("drain_d%0d", d), 32'(q_size(d)), 32'd0);
  endtask

  // Ready driver: one update per cycle, just after the active edge.
  initial begin
    m_ready[0] = 1'b1;
    m_ready[1] = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_ready[0] = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      m_ready[1] = 1'b1;
    end
  end

  // Monitor: compares each transferred byte and verifies outputs hold through stalls.
  initial begin
    int   stalled [2];
    exp_t held    [2];
    exp_t vec;
    exp_t e;
    stalled[0] = 0;
    stalled[1] = 0;
    out_cnt[0] = 0;
    out_cnt[1] = 0;
    pad_cnt[0] = 0;
    pad_cnt[1] = 0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        vec = {m_data[d], m_sop[d], m_last[d], m_pad[d]};
        if (!rst_n) begin
          if (d == 0) exp_q0.delete();
          else        exp_q1.delete();
          stalled[d] = 0;
        end else begin
          if (stalled[d] != 0)
            check($sformatf("hold_d%0d", d), {20'd0, m_valid[d], vec}, {20'd0, 1'b1, held[d]});
          if (m_valid[d] && m_ready[d]) begin
            if (q_size(d) == 0) begin
              check($sformatf("spurious_d%0d", d), 32'd0, 32'd1);
            end else begin
              e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
              check($sformatf("byte_d%0d_n%0d", d, out_cnt[d]), 32'(vec), 32'(e));
            end
            out_cnt[d]++;
            if (m_pad[d]) pad_cnt[d]++;
          end
          stalled[d] = (m_valid[d] && !m_ready[d]) ? 1 : 0;
          held[d]    = vec;
        end
      end
    end
  end

  initial begin
    int fw;
    int base_o;
    int base_p;
    int c;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      s_valid[d] = 1'b0;
      s_data[d]  = 8'h00;
      s_last[d]  = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(m_valid[0]), 32'd0);
    check("rst_flags", {29'd0, m_sop[0], m_last[0], m_pad[0]}, 32'd0);
    check("rst_data", 32'(m_data[0]), 32'd0);
    check("rst_sready", 32'(s_ready[0]), 32'd0);
    check("rst_cnt", {blocks[0], msgs[0]}, 32'd0);
    check("rst_busy", 32'(busy[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1-byte message: A5 then 222 pads.
    base_o = out_cnt[0]; base_p = pad_cnt[0];
    send_msg(0, 223, 8'h00, 1, 8'hA5, fw);
    drain(0, 1000);
    check("t1_bytes", 32'(out_cnt[0] - base_o), 32'd223);
    check("t1_pads", 32'(pad_cnt[0] - base_p), 32'd222);
    check("t1_cnt", {blocks[0], msgs[0]}, {16'd1, 16'd1});
    check("t1_busy", 32'(busy[0]), 32'd0);

    // Exact 223-byte block, then a 224-byte message with no bubble in between.
    base_o = out_cnt[0]; base_p = pad_cnt[0];
    send_msg(0, 223, 8'h00, 223, 8'h00, fw);
    send_msg(0, 223, 8'h00, 224, 8'h00, fw);
    check("t2_no_bubble", 32'(fw), 32'd0);
    drain(0, 2000);
    check("t2_bytes", 32'(out_cnt[0] - base_o), 32'd669);
    check("t2_pads", 32'(pad_cnt[0] - base_p), 32'd222);
    check("t2_cnt", {blocks[0], msgs[0]}, {16'd4, 16'd3});

    // 300-byte message under random backpressure.
    rand_mode = 1'b1;
    base_o = out_cnt[0]; base_p = pad_cnt[0];
    send_msg(0, 223, 8'h00, 300, 8'h37, fw);
    drain(0, 8000);
    rand_mode = 1'b0;
    check("t3_bytes", 32'(out_cnt[0] - base_o), 32'd446);
    check("t3_pads", 32'(pad_cnt[0] - base_p), 32'd146);
    check("t3_cnt", {blocks[0], msgs[0]}, {16'd6, 16'd4});
    repeat (2) @(posedge clk);
    #1;

    // Reset in the middle of the pad run.
    base_o = out_cnt[0];
    send_msg(0, 223, 8'h00, 1, 8'h5A, fw);
    c = 0;
    while ((out_cnt[0] - base_o) < 100 && c < 1000) begin
      @(posedge clk);
      #1;
      c++;
    end
    check("t4_reach_pad", 32'((out_cnt[0] - base_o) >= 100), 32'd1);
    check("t4_busy_pad", 32'(busy[0]), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("t4_async_valid", 32'(m_valid[0]), 32'd0);
    check("t4_async_flags", {21'd0, m_data[0], m_sop[0], m_last[0], m_pad[0]}, 32'd0);
    check("t4_async_cnt", {blocks[0], msgs[0]}, 32'd0);
    check("t4_sready_rst", 32'(s_ready[0]), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    base_o = out_cnt[0]; base_p = pad_cnt[0];
    send_msg(0, 223, 8'h00, 5, 8'h10, fw);
    drain(0, 1000);
    check("t4_bytes", 32'(out_cnt[0] - base_o), 32'd223);
    check("t4_pads", 32'(pad_cnt[0] - base_p), 32'd218);
    check("t4_cnt", {blocks[0], msgs[0]}, {16'd1, 16'd1});

    // K=4, FILL=FF: messages of 3, 4, 5 bytes back-to-back.
    base_o = out_cnt[1]; base_p = pad_cnt[1];
    send_msg(1, 4, 8'hFF, 3, 8'h20, fw);
    send_msg(1, 4, 8'hFF, 4, 8'h30, fw);
    send_msg(1, 4, 8'hFF, 5, 8'h40, fw);
    drain(1, 200);
    check("t5_bytes", 32'(out_cnt[1] - base_o), 32'd16);
    check("t5_pads", 32'(pad_cnt[1] - base_p), 32'd4);
    check("t5_cnt", {blocks[1], msgs[1]}, {16'd4, 16'd3});
    check("t5_busy", 32'(busy[1]), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
